cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run/step controller in the divided CPU clock domain; sits directly downstream of the board-clock divider and is clocked by its output clk.
- Conditions the run switch and step button from the board: 2-flop synchroniser, then debounce.
- Drives the CPU clock enable: free-run, single-step, halt on CPU halt request.
- Keeps a retired-cycle counter for display.

Parameters:
- DB_CYCLES, 16, consecutive stable cycles required before a debounced input changes (must be >= 2).
- DB_W, 5, width of the debounce counter (must hold DB_CYCLES-1).
- CNT_W, 16, width of cycle_cnt.

Ports:
- clk  input  1  divided CPU clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run_sw  input  1  raw run switch, asynchronous; 1 = run.
- step_btn  input  1  raw step push-button, asynchronous; 1 = pressed.
- halt_req  input  1  synchronous CPU halt request (halt instruction retired).
- cpu_en  output  1  CPU clock enable.
- state  output  2  FSM state for LEDs: 00 HALT, 01 RUN, 10 STEP, 11 STOPPED.
- cycle_cnt  output  CNT_W  count of cycles with cpu_en=1.

Behaviour:
- Interface clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, async):
  - sync flops, debounced values, debounce counters and the edge-detect flop all clear to 0.
  - state=HALT, cpu_en=0, cycle_cnt=0.
  - Reset asserted mid-step or mid-run aborts immediately; no pending step survives.
- Synchroniser: each raw input passes 2 flops; s2 is valid after the 2nd edge.
- Debounce (per input, independent):
  - if s2==db, cnt<=0.
  - else if cnt==DB_CYCLES-1, db<=s2 and cnt<=0.
  - else cnt<=cnt+1.
  - A glitch shorter than DB_CYCLES cycles never changes db; any return to equality restarts the count.
- Step edge: step_pulse = step_db & ~step_db_d, where step_db_d is a registered copy of step_db.
  - Exactly one cycle per press; holding the button gives no repeats.
  - Release never pulses.
- FSM (registered), transitions:
  - HALT: run_db=1 -> RUN; else step_pulse -> STEP; else stay. run_db has priority over step_pulse.
  - RUN: halt_req=1 -> STOPPED; else run_db=0 -> HALT. halt_req has priority.
  - STEP: unconditionally -> HALT next cycle, even if halt_req=1.
  - STOPPED: run_db=0 -> HALT; step_pulse ignored; only switching run off exits.
- cpu_en (combinational from state and halt_req):
  - cpu_en = (state==RUN & ~halt_req) | (state==STEP).
  - The cycle that raises halt_req does not advance the CPU.
- Latency: raw change held stable -> db change at the (2+DB_CYCLES)th edge.
  - run_sw rise -> cpu_en=1 after edge 3+DB_CYCLES.
  - step_btn rise -> one-cycle cpu_en after edge 3+DB_CYCLES.
- cycle_cnt: +1 on each edge where cpu_en=1; wraps from all-ones to 0; holds otherwise.

Optional Feature:
- Macro: CPU_RUN_CYCLE_CNT_EN.
- Defined: cycle_cnt counter implemented as above.
- Undefined: no counter flops; cycle_cnt tied to 0. All other behaviour identical.

Test Plan (all scenarios use DB_CYCLES=4, CNT_W=16):
- Reset then run: release rst_n; raise run_sw at edge 0 -> state=01 and cpu_en=1 from edge 7; cycle_cnt=5 after edge 12.
- Single step: in HALT, press step_btn for 20 cycles at edge 0 -> cpu_en=1 for exactly one cycle after edge 7, back to HALT after edge 8. A second press gives cycle_cnt=2.
- Bounce rejection: toggle run_sw 1/0 with 3-cycle high pulses for 30 cycles -> run_db stays 0, cpu_en stays 0, state=00 throughout.
- Halt request: in RUN, pulse halt_req for 1 cycle -> cpu_en=0 that cycle, state=11 next edge.
  - step_btn press while STOPPED -> no cpu_en.
  - run_sw low -> HALT at edge 7 after the change.
- Priority/async reset:
  - In HALT, run_sw and step_btn debounced on the same edge -> RUN, no STEP.
  - Assert rst_n low mid-RUN between edges -> cpu_en=0 and cycle_cnt=0 immediately, before the next clk edge.
- Wrap and macro: preload via 65535 enabled cycles -> cycle_cnt wraps to 0 on the next enabled cycle. With CPU_RUN_CYCLE_CNT_EN undefined, cycle_cnt stays 0 in all tests.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step clock-enable controller: synchronises and debounces run/step, gates the CPU clock enable.
// Optional retired-cycle counter built only when CPU_RUN_CYCLE_CNT_EN is defined; otherwise cycle_cnt reads 0.
module cpu_run_ctrl #(
   parameter int DB_CYCLES = 16,
   parameter int DB_W      = 5,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run_sw,
   input  logic             step_btn,
   input  logic             halt_req,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [1:0] {
      ST_HALT    = 2'b00,
      ST_RUN     = 2'b01,
      ST_STEP    = 2'b10,
      ST_STOPPED = 2'b11
   } state_t;

   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

   // bit 0 = run switch, bit 1 = step button
   logic [1:0]            r_s1;
   logic [1:0]            r_s2;
   logic [1:0]            r_db;
   logic [1:0][DB_W-1:0]  r_db_cnt;
   logic                  r_step_db_d;
   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_cpu_en;
   logic                  w_run_db;
   logic                  w_step_pulse;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1        <= '0;
         r_s2        <= '0;
         r_db        <= '0;
         r_db_cnt    <= '0;
         r_step_db_d <= 1'b0;
      end else begin
         r_s1        <= {step_btn, run_sw};
         r_s2        <= r_s1;
         r_step_db_d <= r_db[1];
         for (int i = 0; i < 2; i++) begin
            if (r_s2[i] == r_db[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_MAX) begin
               r_db[i]     <= r_s2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_run_db     = r_db[0];
   assign w_step_pulse = r_db[1] & ~r_step_db_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_HALT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // cpu_en stays combinational on halt_req so the halting cycle never advances the CPU
   always_comb begin
      w_state_nxt = r_state;
      w_cpu_en    = 1'b0;
      case (r_state)
         ST_HALT: begin
            if (w_run_db) begin
               w_state_nxt = ST_RUN;
            end else if (w_step_pulse) begin
               w_state_nxt = ST_STEP;
            end
         end
         ST_RUN: begin
            w_cpu_en = ~halt_req;
            if (halt_req) begin
               w_state_nxt = ST_STOPPED;
            end else if (!w_run_db) begin
               w_state_nxt = ST_HALT;
            end
         end
         ST_STEP: begin
            w_cpu_en    = 1'b1;
            w_state_nxt = ST_HALT;
         end
         ST_STOPPED: begin
            if (!w_run_db) begin
               w_state_nxt = ST_HALT;
            end
         end
         default: w_state_nxt = ST_HALT;
      endcase
   end

   assign cpu_en = w_cpu_en;
   assign state  = r_state;

`ifdef CPU_RUN_CYCLE_CNT_EN
   logic [CNT_W-1:0] r_cycle_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt <= '0;
      end else if (w_cpu_en) begin
         r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
`else
   assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DB_CYCLES=4; counter expectations follow CPU_RUN_CYCLE_CNT_EN.
module tb_cpu_run_ctrl;

   logic        clk;
   logic        rst_n;
   logic        run_sw;
   logic        step_btn;
   logic        halt_req;
   logic        cpu_en;
   logic [1:0]  state;
   logic [15:0] cycle_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int en_cnt;
   int viol;

   cpu_run_ctrl #(
      .DB_CYCLES (4),
      .DB_W      (5),
      .CNT_W     (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run_sw    (run_sw),
      .step_btn  (step_btn),
      .halt_req  (halt_req),
      .cpu_en    (cpu_en),
      .state     (state),
      .cycle_cnt (cycle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ce(input int v);
`ifdef CPU_RUN_CYCLE_CNT_EN
      return 32'(v);
`else
      return (v == 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset;
      run_sw   = 1'b0;
      step_btn = 1'b0;
      halt_req = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      tick(3);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      run_sw   = 1'b0;
      step_btn = 1'b0;
      halt_req = 1'b0;
      #2;
      check_eq("rst_state", 32'(state), 32'd0);
      check_eq("rst_en", 32'(cpu_en), 32'd0);
      check_eq("rst_cnt", 32'(cycle_cnt), 32'd0);
      tick(2);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // reset then run
      tick(1);
      run_sw = 1'b1;
      tick(6);
      check_eq("run_e6_state", 32'(state), 32'd0);
      check_eq("run_e6_en", 32'(cpu_en), 32'd0);
      tick(1);
      check_eq("run_e7_state", 32'(state), 32'd1);
      check_eq("run_e7_en", 32'(cpu_en), 32'd1);
      tick(5);
      check_eq("run_e12_cnt", 32'(cycle_cnt), ce(5));

      // single step
      do_reset();
      tick(1);
      step_btn = 1'b1;
      tick(6);
      check_eq("step_e6_en", 32'(cpu_en), 32'd0);
      tick(1);
      check_eq("step_e7_state", 32'(state), 32'd2);
      check_eq("step_e7_en", 32'(cpu_en), 32'd1);
      tick(1);
      check_eq("step_e8_state", 32'(state), 32'd0);
      check_eq("step_e8_en", 32'(cpu_en), 32'd0);
      check_eq("step_e8_cnt", 32'(cycle_cnt), ce(1));
      en_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         en_cnt += int'(cpu_en);
      end
      step_btn = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         en_cnt += int'(cpu_en);
      end
      check_eq("step_hold_release_en", 32'(en_cnt), 32'd0);
      step_btn = 1'b1;
      en_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         en_cnt += int'(cpu_en);
      end
      check_eq("step2_en_cycles", 32'(en_cnt), 32'd1);
      check_eq("step2_cnt", 32'(cycle_cnt), ce(2));
      step_btn = 1'b0;
      tick(10);

      // bounce rejection
      do_reset();
      viol = 0;
      for (int i = 0; i < 30; i++) begin
         run_sw = ((i % 6) < 3);
         tick(1);
         if (cpu_en !== 1'b0 || state !== 2'b00) viol++;
      end
      run_sw = 1'b0;
      tick(10);
      check_eq("bounce_viol", 32'(viol), 32'd0);
      check_eq("bounce_state", 32'(state), 32'd0);

      // halt request
      do_reset();
      run_sw = 1'b1;
      tick(8);
      check_eq("halt_pre_state", 32'(state), 32'd1);
      halt_req = 1'b1;
      #1;
      check_eq("halt_req_en", 32'(cpu_en), 32'd0);
      tick(1);
      halt_req = 1'b0;
      check_eq("halt_state", 32'(state), 32'd3);
      check_eq("halt_cnt", 32'(cycle_cnt), ce(1));
      step_btn = 1'b1;
      en_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         en_cnt += int'(cpu_en);
      end
      step_btn = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         en_cnt += int'(cpu_en);
      end
      check_eq("stopped_step_en", 32'(en_cnt), 32'd0);
      check_eq("stopped_state", 32'(state), 32'd3);
      run_sw = 1'b0;
      tick(6);
      check_eq("unstop_e6_state", 32'(state), 32'd3);
      tick(1);
      check_eq("unstop_e7_state", 32'(state), 32'd0);

      // run has priority over step on the same debounce edge
      do_reset();
      run_sw   = 1'b1;
      step_btn = 1'b1;
      tick(6);
      check_eq("prio_e6_state", 32'(state), 32'd0);
      tick(1);
      check_eq("prio_e7_state", 32'(state), 32'd1);
      tick(1);
      check_eq("prio_e8_state", 32'(state), 32'd1);
      check_eq("prio_e8_en", 32'(cpu_en), 32'd1);
      check_eq("prio_e8_cnt", 32'(cycle_cnt), ce(1));

      // asynchronous reset between edges
      #1 rst_n = 1'b0;
      #1;
      check_eq("arst_en", 32'(cpu_en), 32'd0);
      check_eq("arst_cnt", 32'(cycle_cnt), 32'd0);
      check_eq("arst_state", 32'(state), 32'd0);
      step_btn = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;

      // counter wrap
      tick(7);
      check_eq("wrap_start_en", 32'(cpu_en), 32'd1);
      check_eq("wrap_start_cnt", 32'(cycle_cnt), 32'd0);
      tick(65535);
      check_eq("wrap_full_cnt", 32'(cycle_cnt), ce(65535));
      tick(1);
      check_eq("wrap_zero_cnt", 32'(cycle_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
